// File: rtl/uart_tx_dev_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_dev_if
// Description : Device-bus bundle shared with the timer devices: word
//               address, write strobe, write data, combinational read data
//               and a level interrupt request.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_dev_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  // Bridge / CPU side
  modport master (
    output Addr,
    output WE,
    output Din,
    input  Dout,
    input  IRQ
  );

  // Device side
  modport slave (
    input  Addr,
    input  WE,
    input  Din,
    output Dout,
    output IRQ
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_dev.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_dev
// Description : Memory-mapped 8N1 serial transmitter. Bytes written to DATA
//               are queued in a small FIFO and shifted out LSB first on txd.
//               IRQ signals that the transmitter has fully drained.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_dev #(
  parameter int DEPTH       = 4,
  parameter int DEFAULT_DIV = 16
) (
  input  wire logic   clk,
  input  wire logic   reset,
  uart_tx_dev_if.slave bus,
  output logic        txd
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] c_ADDR_DIV    = 2'd1;
  localparam logic [1:0] c_ADDR_DATA   = 2'd2;
  localparam logic [1:0] c_ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Registers
  logic [1:0]    r_ctrl;      // [1]=IE, [0]=EN
  logic [15:0]   r_div;
  logic          r_ovf;
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  state_t        r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitidx;
  logic [15:0]   r_timer;     // cycles left in the current bit period, minus one
  logic          r_txd;
  logic          r_irq;

  // Combinational helpers
  state_t        w_next;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push;
  logic          w_empty;
  logic          w_full;
  logic          w_bit_end;
  logic          w_reload;
  logic [15:0]   w_div_eff;
  logic [7:0]    w_shift_next;
  logic          w_txd_next;
  logic [7:0]    w_count8;
  logic          w_unused;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (PW+1)'(DEPTH));
  assign w_bit_end  = (r_timer == 16'd0);
  // A divider of zero would stall the timer, so it behaves as one cycle per bit
  assign w_div_eff  = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_push_req = bus.WE && (bus.Addr == c_ADDR_DATA);
  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_count8   = 8'(r_count);
  assign w_unused   = ^bus.Din[31:16];

  // Next-state logic of the frame sequencer
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ctrl[0] && !w_empty) begin
          w_pop  = 1'b1;
          w_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) w_next = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && (r_bitidx == 3'd7)) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Next shift-register contents, line level and timer reload decision
  always_comb begin
    w_shift_next = r_shift;
    if (w_pop) begin
      w_shift_next = r_mem[r_rd_ptr];
    end else if ((r_state == S_DATA) && w_bit_end) begin
      w_shift_next = {1'b0, r_shift[7:1]};
    end
    case (w_next)
      S_START: w_txd_next = 1'b0;
      S_DATA:  w_txd_next = w_shift_next[0];
      default: w_txd_next = 1'b1;
    endcase
    // Every new bit period re-samples DIV, so mid-frame writes hit later bits only
    w_reload = w_pop || ((r_state != S_IDLE) && w_bit_end && (w_next != S_IDLE));
  end

  // Frame sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Bit timer, shift register, bit index and registered serial output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer  <= 16'd0;
      r_shift  <= 8'd0;
      r_bitidx <= 3'd0;
      r_txd    <= 1'b1;
    end else begin
      if (w_reload)                               r_timer <= w_div_eff - 16'd1;
      else if ((r_state != S_IDLE) && !w_bit_end) r_timer <= r_timer - 16'd1;
      r_shift <= w_shift_next;
      if (w_bit_end && (r_state == S_START))     r_bitidx <= 3'd0;
      else if (w_bit_end && (r_state == S_DATA)) r_bitidx <= r_bitidx + 3'd1;
      r_txd <= w_txd_next;
    end
  end

  // Control registers and the sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl <= 2'd0;
      r_div  <= 16'(DEFAULT_DIV);
      r_ovf  <= 1'b0;
    end else begin
      if (bus.WE && (bus.Addr == c_ADDR_CTRL)) r_ctrl <= bus.Din[1:0];
      if (bus.WE && (bus.Addr == c_ADDR_DIV))  r_div  <= bus.Din[15:0];
      if (bus.WE && (bus.Addr == c_ADDR_STATUS)) r_ovf <= 1'b0;
      else if (w_push_req && !w_push)           r_ovf <= 1'b1;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (PW+1)'(1);
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.Din[7:0];
  end

  // Drained-transmitter interrupt, one cycle behind its condition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= r_ctrl[1] && r_ctrl[0] && w_empty && (r_state == S_IDLE);
  end

  // Combinational register read-back
  always_comb begin
    bus.Dout = 32'd0;
    case (bus.Addr)
      c_ADDR_CTRL:   bus.Dout = {30'd0, r_ctrl};
      c_ADDR_DIV:    bus.Dout = {16'd0, r_div};
      c_ADDR_DATA:   bus.Dout = 32'd0;
      c_ADDR_STATUS: bus.Dout = {20'd0, r_ovf, w_full, w_empty,
                                 (r_state != S_IDLE), w_count8};
      default:       bus.Dout = 32'd0;
    endcase
  end

  assign bus.IRQ = r_irq;
  assign txd     = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_dev.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_dev
// Description : Directed self-checking bench for the uart_tx_dev transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_dev;

  logic clk;
  logic reset;
  logic txd;
  int   n_cmp;
  int   n_err;

  uart_tx_dev_if bus ();

  uart_tx_dev #(
    .DEPTH       (4),
    .DEFAULT_DIV (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .txd   (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One bus write; returns 1ns after the edge that performs it
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.Addr = a;
    bus.Din  = d;
    bus.WE   = 1'b1;
    @(posedge clk);
    #1;
    bus.WE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.Addr = a;
    #1;
    chk(tag, bus.Dout, exp);
  endtask

  // Follows one frame cycle by cycle, starting right after the edge that queued/enabled it
  task automatic frame(input logic [7:0] b, input int div, input bit chk_irq);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    bus.Addr = 2'd3;
    #1;
    chk($sformatf("pre_busy_%02h", b), {31'd0, bus.Dout[8]}, 32'd0);
    chk($sformatf("pre_txd_%02h", b), {31'd0, txd}, 32'd1);
    for (int i = 0; i < 10 * div; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("txd_%02h_c%0d", b, i), {31'd0, txd}, {31'd0, bits[i / div]});
      chk($sformatf("busy_%02h_c%0d", b, i), {31'd0, bus.Dout[8]}, 32'd1);
      if (chk_irq && (i == 1)) chk("irq_low", {31'd0, bus.IRQ}, 32'd0);
    end
    @(posedge clk);
    #1;
    chk($sformatf("idle_txd_%02h", b), {31'd0, txd}, 32'd1);
    chk($sformatf("idle_busy_%02h", b), {31'd0, bus.Dout[8]}, 32'd0);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    bus.Addr = 2'd0;
    bus.WE   = 1'b0;
    bus.Din  = 32'd0;

    // Step 1: reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_irq", {31'd0, bus.IRQ}, 32'd0);
    rd_chk("rst_ctrl", 2'd0, 32'h0);
    rd_chk("rst_div", 2'd1, 32'h10);
    rd_chk("rst_data", 2'd2, 32'h0);
    rd_chk("rst_status", 2'd3, 32'h200);

    // Step 2: single 0xA5 frame at 4 cycles per bit
    wr(2'd1, 32'd4);
    wr(2'd0, 32'd1);
    rd_chk("ctrl_en", 2'd0, 32'h1);
    wr(2'd2, 32'hA5);
    frame(8'hA5, 4, 1'b0);
    rd_chk("st_after_a5", 2'd3, 32'h200);

    // Step 3: fill with EN off, overflow, clear OVF, then drain in order
    wr(2'd0, 32'd0);
    wr(2'd2, 32'h11);
    wr(2'd2, 32'h22);
    wr(2'd2, 32'h33);
    wr(2'd2, 32'h44);
    wr(2'd2, 32'h55);
    rd_chk("st_full_ovf", 2'd3, 32'hC04);
    repeat (3) @(posedge clk);
    #1;
    chk("txd_hold_dis", {31'd0, txd}, 32'd1);
    wr(2'd3, 32'hFFFF_FFFF);
    rd_chk("st_ovf_clr", 2'd3, 32'h404);
    wr(2'd0, 32'd1);
    frame(8'h11, 4, 1'b0);
    frame(8'h22, 4, 1'b0);
    frame(8'h33, 4, 1'b0);
    frame(8'h44, 4, 1'b0);
    rd_chk("st_drained", 2'd3, 32'h200);

    // Step 4: drained interrupt
    wr(2'd0, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_idle", {31'd0, bus.IRQ}, 32'd1);
    wr(2'd2, 32'h00);
    frame(8'h00, 4, 1'b1);
    chk("irq_at_idle", {31'd0, bus.IRQ}, 32'd0);
    @(posedge clk);
    #1;
    chk("irq_back", {31'd0, bus.IRQ}, 32'd1);

    // Step 5: asynchronous reset in the middle of the data bits
    wr(2'd0, 32'd1);
    wr(2'd2, 32'h3C);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_txd_bit1", {31'd0, txd}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_txd", {31'd0, txd}, 32'd1);
    rd_chk("async_status", 2'd3, 32'h200);
    rd_chk("async_div", 2'd1, 32'h10);
    rd_chk("async_ctrl", 2'd0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_txd_c%0d", i), {31'd0, txd}, 32'd1);
    end
    rd_chk("post_rst_status", 2'd3, 32'h200);

    // Step 6: DIV=0 behaves as one cycle per bit
    wr(2'd1, 32'd0);
    wr(2'd0, 32'd1);
    rd_chk("div_zero", 2'd1, 32'h0);
    wr(2'd2, 32'hFF);
    frame(8'hFF, 1, 1'b0);
    rd_chk("st_end", 2'd3, 32'h200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_dev.md
Name: uart_tx_dev

Overview:
Memory-mapped serial transmitter on the Bridge's device bus, alongside the two timer devices. It uses the same device interface as the timers: word address, write enable, write data, combinational read data and a level IRQ. The CPU writes bytes into a small TX FIFO. An FSM serialises each byte as 8N1 frames on `txd`. IRQ is raised when the transmitter has drained, so the Bridge can route it as an external interrupt line.

Parameters:
- DEPTH, 4, TX FIFO entries (power of two, ≥2).
- DEFAULT_DIV, 16, reset value of the DIV register (cycles per bit).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- Addr  input  2  register select (word address bits [3:2]): 0=CTRL, 1=DIV, 2=DATA, 3=STATUS.
- WE  input  1  write strobe; write performed at posedge when high.
- Din  input  32  write data.
- Dout  output  32  read data, combinational from Addr.
- IRQ  output  1  level interrupt request.
- txd  output  1  serial line, idle high, registered.

Behaviour:
- Reset values:
  - CTRL=0 (EN bit0, IE bit1).
  - DIV=DEFAULT_DIV.
  - FIFO empty, count=0; OVF=0.
  - FSM=IDLE; txd=1; IRQ=0.
- Register writes:
  - CTRL takes Din[1:0].
  - DIV takes Din[15:0].
  - DATA pushes Din[7:0].
  - STATUS: any write clears OVF.
- Register reads:
  - CTRL={30'b0,IE,EN}.
  - DIV={16'b0,DIV}.
  - DATA reads 0.
  - STATUS: [7:0]=count, [8]=busy (FSM≠IDLE), [9]=empty, [10]=full, [11]=OVF, rest 0.
- FIFO push rule:
  - Accepted iff count<DEPTH, or a pop occurs in the same cycle.
  - Otherwise the byte is dropped and OVF is set (sticky).
  - Pointers wrap modulo DEPTH.
  - Simultaneous push+pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if EN && !empty, pop the head into the shift register, load the bit timer, go to START. txd=0 from the next cycle.
  - START: txd=0 for one bit period, then DATA with bit index 0.
  - DATA: txd=shift[0], LSB first; shift right at the end of each bit period. After bit 7 go to STOP.
  - STOP: txd=1 for one bit period, then IDLE.
  - A new frame can start the cycle after returning to IDLE, so there is one idle cycle between back-to-back frames.
- Bit period:
  - Equals DIV cycles; DIV=0 is treated as 1.
  - DIV is sampled at the start of each bit period, so a mid-frame DIV write affects only subsequent bits.
- EN cleared mid-frame: the current frame completes; no further pops happen; FIFO contents are retained.
- IRQ = IE && EN && empty && FSM==IDLE. It is a registered level with one cycle of latency after the condition changes.
- Latency: with EN=1, FIFO empty, FSM idle, a DATA write at edge t gives FSM=START and txd=0 after edge t+1.
- Asynchronous reset mid-frame: txd=1, FIFO and OVF cleared, FSM=IDLE, all without waiting for clk.
- Dout during reset reflects the reset register values.

Test Plan:
1. Assert reset, release → txd=1, IRQ=0; read DIV=0x10; STATUS=0x200 (empty).
2. Write DIV=4, CTRL=1, DATA=0xA5 → starting one cycle after the DATA edge, txd carries:
   - start bit 0 for 4 cycles;
   - data bits 1,0,1,0,0,1,0,1, 4 cycles each;
   - stop bit 1 for 4 cycles.
   STATUS[8]=1 for exactly those 40 cycles.
3. CTRL=0, write DATA 5 times → STATUS=0xC04 (count=4, full, OVF); txd stays 1. Write STATUS → STATUS=0x404. Then CTRL=1 → 4 frames transmitted in FIFO order.
4. CTRL=3, FIFO empty → IRQ=1. Write DATA=0x00 → IRQ=0 within 2 cycles; IRQ returns to 1 one cycle after the stop bit ends.
5. DIV=4, frame in progress, assert reset during the data bits → txd=1 immediately (asynchronous). After release, STATUS=0x200 and no residual frame appears.
6. DIV=0, CTRL=1, write DATA=0xFF → complete frame lasts 10 cycles (start 0, eight 1s, stop 1).
